iter_compare_unit: RTL
======================

Name: iter_compare_unit

Overview:
Multi-cycle, parametrised compare/subtract unit for the ALU execute path. It computes X - Y as X + ~Y + 1, CHUNK bits per clock, carrying the ripple carry between cycles, and returns one of four results selected by op: set-less-than signed, set-less-than unsigned, equality, or raw difference. Compared with the single-cycle 16-bit less-than block, it adds unsigned compare, equality, overflow-correct signed compare and MIPS-style 0/1 results. Operands enter and results leave through valid/ready handshakes, so the pipeline controller can stall around it.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits processed per RUN cycle; N = WIDTH/CHUNK cycles per operation.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands and op are presented
in_ready  output  1  unit can accept a new operation this cycle
op  input  2  00 SLT signed, 01 SLTU unsigned, 10 SUB, 11 EQ
x  input  WIDTH  minuend
y  input  WIDTH  subtrahend
out_valid  output  1  result fields are valid
out_ready  input  1  consumer accepts the result
result  output  WIDTH  SLT/SLTU/EQ: zero-extended 0 or 1; SUB: difference
diff  output  WIDTH  x - y, modulo 2^WIDTH, for every op
lt  output  1  less-than flag of the selected signedness (0 for SUB/EQ)
ovf  output  1  signed overflow of x - y
zero  output  1  diff == 0

Behaviour:
- Reset: all registers are cleared. State is IDLE, in_ready=1, out_valid=0, result=0, diff=0, lt=0, ovf=0, zero=0, and the counter is 0. Reset has priority over all other inputs.
- FSM states:
  - IDLE: in_ready=1. On in_valid, x, y and op are latched, carry is set to 1, cnt is set to 0, and the state goes to RUN.
  - RUN: in_ready=0, and in_valid is ignored. Each edge adds chunk cnt of x and chunk cnt of ~y, plus carry, writing into diff[cnt*CHUNK +: CHUNK]. The carry-out is stored and cnt increments. On the edge where cnt == N-1, the flags are computed and the state goes to DONE.
  - DONE: out_valid=1, and all outputs hold stable until out_ready.
    - out_ready and not in_valid: go to IDLE.
    - out_ready and in_valid in the same cycle: accept the new operation immediately and go to RUN. This is back-to-back operation, with no IDLE bubble.
- in_ready = (state==IDLE) or (state==DONE and out_ready); this is combinational.
- Latency: if the operation is accepted at edge k, out_valid is high after edge k+N. Throughput is one operation per N+1 cycles when out_ready is held high.
- Flag rules, applied to the full-width diff:
  - cout is the carry out of the final chunk.
  - ovf = (x[MSB] != y[MSB]) and (diff[MSB] != x[MSB]).
  - Signed lt = diff[MSB] xor ovf.
  - Unsigned lt = not cout.
  - zero = (diff == 0).
  - EQ result = zero.
- result is WIDTH bits. The compare ops put the flag in bit 0 with all other bits 0 (not a replicated mask). SUB returns diff.
- Outputs during RUN are don't-care for the consumer. The implementation holds out_valid=0.
- Reset asserted mid-RUN or in DONE aborts the operation. The result is lost and IDLE is entered on that edge.
- out_ready while out_valid=0 has no effect.
- WIDTH not a multiple of CHUNK is a configuration error and is flagged by an elaboration-time check.

Test Plan:
1. WIDTH=16, CHUNK=4. SLT with x=0xFFFF, y=0x0001 → after 4 cycles: out_valid=1, diff=0xFFFE, lt=1, result=0x0001, ovf=0. The same operands with SLTU → lt=0, result=0x0000.
2. SLT with x=0x8000, y=0x0001 → diff=0x7FFF, ovf=1, lt=1, result=0x0001. This is the overflow case where an MSB-only compare gives the wrong answer. SLT with x=0x7FFF, y=0xFFFF → ovf=1, lt=0.
3. EQ with x=y=0x1234 → zero=1, result=0x0001. SUB with x=0x0005, y=0x0003 → result=0x0002, lt=0. SUB with x=0x0000, y=0x0001 → result=0xFFFF, with cout=0 reflected in SLTU semantics.
4. Back-pressure: hold out_ready=0 for 5 cycles after DONE → outputs remain stable, in_ready=0, and in_valid pulses are ignored. Raising out_ready together with in_valid → the new operation is accepted that edge and its out_valid appears N edges later.
5. Reset pulsed for one cycle at the second RUN cycle → the next cycle shows IDLE, in_ready=1, out_valid=0 and all outputs 0. A following SLTU with x=0x0001, y=0x0002 completes normally with result=0x0001.
6. Parameter sweep over WIDTH=32 with CHUNK=8, and WIDTH=16 with CHUNK=16 (single cycle) → latency equals N. 1000 random operations are checked against a reference model for diff, lt, ovf, zero and result.

Source files
------------

// File: rtl/iter_compare_unit.sv
// Multi-cycle compare/subtract unit: computes x - y as x + ~y + 1, CHUNK bits per clock,
// and returns SLT / SLTU / SUB / EQ results through valid/ready handshakes.
module iter_compare_unit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] diff,
  output logic             lt,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] OP_SLT  = 2'b00;
  localparam logic [1:0] OP_SLTU = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_EQ   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  generate
    if (WIDTH % CHUNK != 0) begin : g_cfg_check
      $error("iter_compare_unit: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t           state_r, state_nxt;
  logic [WIDTH-1:0] x_r, y_r, diff_r, result_r;
  logic [1:0]       op_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             lt_r, ovf_r, zero_r;

  logic             accept;
  int               base;
  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] diff_nxt, result_nxt;
  logic             ovf_nxt, zero_nxt, lt_nxt;

  assign accept = in_valid & in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt;
  end

  // Next-state logic; DONE with out_ready and in_valid chains straight into RUN
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    state_nxt = in_valid ? RUN : IDLE;
      RUN:     state_nxt = (cnt_r == LAST) ? DONE : RUN;
      DONE: begin
        if (out_ready) state_nxt = in_valid ? RUN : IDLE;
        else           state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE:    in_ready  = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // One chunk of the ripple add plus flag derivation from the completed difference
  always_comb begin
    base     = int'(cnt_r) * CHUNK;
    sum      = {1'b0, x_r[base +: CHUNK]} + {1'b0, ~y_r[base +: CHUNK]} + {{CHUNK{1'b0}}, carry_r};
    diff_nxt = diff_r;
    diff_nxt[base +: CHUNK] = sum[CHUNK-1:0];
    ovf_nxt  = (x_r[WIDTH-1] != y_r[WIDTH-1]) && (diff_nxt[WIDTH-1] != x_r[WIDTH-1]);
    zero_nxt = (diff_nxt == {WIDTH{1'b0}});
    case (op_r)
      OP_SLT: begin
        lt_nxt     = diff_nxt[WIDTH-1] ^ ovf_nxt;
        result_nxt = {{(WIDTH-1){1'b0}}, lt_nxt};
      end
      OP_SLTU: begin
        lt_nxt     = ~sum[CHUNK];
        result_nxt = {{(WIDTH-1){1'b0}}, lt_nxt};
      end
      OP_SUB: begin
        lt_nxt     = 1'b0;
        result_nxt = diff_nxt;
      end
      OP_EQ: begin
        lt_nxt     = 1'b0;
        result_nxt = {{(WIDTH-1){1'b0}}, zero_nxt};
      end
      default: begin
        lt_nxt     = 1'b0;
        result_nxt = {WIDTH{1'b0}};
      end
    endcase
  end

  // Operand capture, chunk iteration and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r      <= {WIDTH{1'b0}};
      y_r      <= {WIDTH{1'b0}};
      op_r     <= 2'b00;
      carry_r  <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      diff_r   <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      lt_r     <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
    end else if (accept) begin
      x_r      <= x;
      y_r      <= y;
      op_r     <= op;
      carry_r  <= 1'b1;
      cnt_r    <= {CW{1'b0}};
      diff_r   <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      lt_r     <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
    end else if (state_r == RUN) begin
      diff_r  <= diff_nxt;
      carry_r <= sum[CHUNK];
      cnt_r   <= cnt_r + CW'(1);
      if (cnt_r == LAST) begin
        result_r <= result_nxt;
        lt_r     <= lt_nxt;
        ovf_r    <= ovf_nxt;
        zero_r   <= zero_nxt;
      end
    end
  end

  assign result = result_r;
  assign diff   = diff_r;
  assign lt     = lt_r;
  assign ovf    = ovf_r;
  assign zero   = zero_r;

endmodule
